// File: rtl/regbus_arbiter_pkg.sv
// Shared types for the two-master register-bus arbiter.
// FSM state encoding and master-index width.
package regbus_arbiter_pkg;

  localparam int MIDXW = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

endpackage

// File: rtl/regbus_arbiter_if.sv
// Register-bus bundle: two masters, one registered slave.
// master = requester/slave-model side, slave = arbiter side.
interface regbus_arbiter_if #(
  parameter int DATAW = 8,
  parameter int ADDRW = 8
);

  logic             i_m0_req;
  logic             i_m0_we;
  logic [ADDRW-1:0] i_m0_addr;
  logic [DATAW-1:0] i_m0_wdata;
  logic             o_m0_ack;
  logic [DATAW-1:0] o_m0_rdata;

  logic             i_m1_req;
  logic             i_m1_we;
  logic [ADDRW-1:0] i_m1_addr;
  logic [DATAW-1:0] i_m1_wdata;
  logic             o_m1_ack;
  logic [DATAW-1:0] o_m1_rdata;

  logic             o_s_we;
  logic [ADDRW-1:0] o_s_addr;
  logic [DATAW-1:0] o_s_wdata;
  logic [DATAW-1:0] i_s_rdata;

  logic             o_busy;

  modport master (
    output i_m0_req, i_m0_we, i_m0_addr, i_m0_wdata,
    input  o_m0_ack, o_m0_rdata,
    output i_m1_req, i_m1_we, i_m1_addr, i_m1_wdata,
    input  o_m1_ack, o_m1_rdata,
    input  o_s_we, o_s_addr, o_s_wdata,
    output i_s_rdata,
    input  o_busy
  );

  modport slave (
    input  i_m0_req, i_m0_we, i_m0_addr, i_m0_wdata,
    output o_m0_ack, o_m0_rdata,
    input  i_m1_req, i_m1_we, i_m1_addr, i_m1_wdata,
    output o_m1_ack, o_m1_rdata,
    output o_s_we, o_s_addr, o_s_wdata,
    input  i_s_rdata,
    output o_busy
  );

endinterface

// File: rtl/regbus_arbiter_rr_pick2.sv
// Two-request round-robin picker, purely combinational.
// On contention the master not granted last wins.
module rr_pick2
  import regbus_arbiter_pkg::*;
(
  input  logic [1:0]       i_req,
  input  logic [MIDXW-1:0] i_last,
  output logic             o_vld,
  output logic [MIDXW-1:0] o_idx
);

  // Single request wins; both requesting -> the other one
  always_comb begin
    o_vld = |i_req;
    o_idx = '0;
    unique case (1'b1)
      (i_req == 2'b11): o_idx = ~i_last;
      (i_req == 2'b10): o_idx = MIDXW'(1);
      default:          o_idx = '0;
    endcase
  end

endmodule

// File: rtl/regbus_arbiter.sv
// Two-master arbiter onto a registered register-file slave.
// One transaction per IDLE->ISSUE->WAIT round.
module regbus_arbiter
  import regbus_arbiter_pkg::*;
#(
  parameter int DATAW = 8,
  parameter int ADDRW = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  regbus_arbiter_if.slave  bus
);

  state_e           state_q, state_d;
  logic [MIDXW-1:0] last_q, last_d;
  logic [MIDXW-1:0] gidx_q, gidx_d;
  logic             cmd_we_q, cmd_we_d;
  logic [ADDRW-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATAW-1:0] cmd_wdata_q, cmd_wdata_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic [DATAW-1:0] rdata0_q, rdata0_d;
  logic [DATAW-1:0] rdata1_q, rdata1_d;

  logic [1:0]       req_m;
  logic             pick_vld;
  logic [MIDXW-1:0] pick_idx;

  // A master being acked this cycle sits out arbitration
  assign req_m = {bus.i_m1_req & ~ack1_q,
                  bus.i_m0_req & ~ack0_q};

  rr_pick2 u_pick (
    .i_req  (req_m),
    .i_last (last_q),
    .o_vld  (pick_vld),
    .o_idx  (pick_idx)
  );

  // Next-state, command latch and ack/rdata return
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gidx_d      = gidx_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d = ST_ISSUE;
          gidx_d  = pick_idx;
          last_d  = pick_idx;
          if (pick_idx == MIDXW'(1)) begin
            cmd_we_d    = bus.i_m1_we;
            cmd_addr_d  = bus.i_m1_addr;
            cmd_wdata_d = bus.i_m1_wdata;
          end else begin
            cmd_we_d    = bus.i_m0_we;
            cmd_addr_d  = bus.i_m0_addr;
            cmd_wdata_d = bus.i_m0_wdata;
          end
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        state_d = ST_IDLE;
        if (gidx_q == MIDXW'(1)) begin
          ack1_d   = 1'b1;
          rdata1_d = bus.i_s_rdata;
        end else begin
          ack0_d   = 1'b1;
          rdata0_d = bus.i_s_rdata;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      last_q      <= MIDXW'(1);
      gidx_q      <= '0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gidx_q      <= gidx_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  // Reset gates the write so an aborted ISSUE never lands
  assign bus.o_s_we     = (state_q == ST_ISSUE)
                        & cmd_we_q & ~i_rst;
  assign bus.o_s_addr   = cmd_addr_q;
  assign bus.o_s_wdata  = cmd_wdata_q;
  assign bus.o_m0_ack   = ack0_q;
  assign bus.o_m1_ack   = ack1_q;
  assign bus.o_m0_rdata = rdata0_q;
  assign bus.o_m1_rdata = rdata1_q;
  assign bus.o_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_regbus_arbiter.sv
// Directed bench for regbus_arbiter with a registered
// register-file slave model.
module tb_regbus_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mem_clr = 1'b1;
  logic [7:0] mem [0:255];
  logic [7:0] s_rdata_q;
  int         errs = 0;
  int         checks = 0;

  regbus_arbiter_if #(.DATAW(8), .ADDRW(8)) bus ();

  regbus_arbiter #(.DATAW(8), .ADDRW(8)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Slave: read sampled before write takes effect
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (bus.o_s_we) begin
      mem[bus.o_s_addr] <= bus.o_s_wdata;
    end
    s_rdata_q <= mem[bus.o_s_addr];
  end

  assign bus.i_s_rdata = s_rdata_q;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.i_m0_req = 1'b0;
    bus.i_m1_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mem_clr = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    checks++;
    if (bus.o_m0_ack !== 1'b0 || bus.o_m1_ack !== 1'b0) begin
      errs++;
      $display("FAIL rst_ack: got %b%b want 00",
               bus.o_m1_ack, bus.o_m0_ack);
    end
    checks++;
    if (bus.o_m0_rdata !== 8'h00 || bus.o_m1_rdata !== 8'h00) begin
      errs++;
      $display("FAIL rst_rdata: got %h/%h want 00/00",
               bus.o_m0_rdata, bus.o_m1_rdata);
    end
    checks++;
    if (bus.o_s_we !== 1'b0 || bus.o_s_addr !== 8'h00 ||
        bus.o_s_wdata !== 8'h00) begin
      errs++;
      $display("FAIL rst_slave: got we=%b a=%h d=%h want 0/00/00",
               bus.o_s_we, bus.o_s_addr, bus.o_s_wdata);
    end
    checks++;
    if (bus.o_busy !== 1'b0) begin
      errs++;
      $display("FAIL rst_busy: got %b want 0", bus.o_busy);
    end
  endtask

  task automatic test_write_m0();
    int lat;
    lat = 0;
    @(negedge clk);
    bus.i_m0_we    = 1'b1;
    bus.i_m0_addr  = 8'd2;
    bus.i_m0_wdata = 8'hA5;
    bus.i_m0_req   = 1'b1;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        checks++;
        if (bus.o_s_we !== 1'b1 || bus.o_s_addr !== 8'd2 ||
            bus.o_s_wdata !== 8'hA5 || bus.o_busy !== 1'b1) begin
          errs++;
          $display("FAIL wr_issue: got we=%b a=%h d=%h busy=%b want 1/02/a5/1",
                   bus.o_s_we, bus.o_s_addr, bus.o_s_wdata, bus.o_busy);
        end
      end
      if (k == 2) begin
        checks++;
        if (bus.o_s_we !== 1'b0) begin
          errs++;
          $display("FAIL wr_we_pulse: got %b want 0", bus.o_s_we);
        end
      end
      if (bus.o_m0_ack === 1'b1) begin
        lat = k;
        bus.i_m0_req = 1'b0;
        checks++;
        if (bus.o_m1_ack !== 1'b0) begin
          errs++;
          $display("FAIL wr_other_ack: got %b want 0", bus.o_m1_ack);
        end
      end
    end
    checks++;
    if (lat != 3) begin
      errs++;
      $display("FAIL wr_latency: got %0d want 3", lat);
    end
    checks++;
    if (bus.o_m0_rdata !== 8'h00) begin
      errs++;
      $display("FAIL wr_old_data: got %h want 00", bus.o_m0_rdata);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.o_m0_ack !== 1'b0) begin
      errs++;
      $display("FAIL wr_ack_clear: got %b want 0", bus.o_m0_ack);
    end
    checks++;
    if (mem[2] !== 8'hA5) begin
      errs++;
      $display("FAIL wr_mem: got %h want a5", mem[2]);
    end
  endtask

  task automatic test_read_m1();
    int lat;
    logic we_seen;
    lat = 0;
    we_seen = 1'b0;
    @(negedge clk);
    bus.i_m1_we    = 1'b0;
    bus.i_m1_addr  = 8'd2;
    bus.i_m1_wdata = 8'hFF;
    bus.i_m1_req   = 1'b1;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (bus.o_s_we !== 1'b0) we_seen = 1'b1;
      if (bus.o_m1_ack === 1'b1) begin
        lat = k;
        bus.i_m1_req = 1'b0;
      end
    end
    checks++;
    if (we_seen !== 1'b0) begin
      errs++;
      $display("FAIL rd_we: got 1 want 0");
    end
    checks++;
    if (lat != 3) begin
      errs++;
      $display("FAIL rd_latency: got %0d want 3", lat);
    end
    checks++;
    if (bus.o_m1_rdata !== 8'hA5) begin
      errs++;
      $display("FAIL rd_data: got %h want a5", bus.o_m1_rdata);
    end
    checks++;
    if (bus.o_m0_rdata !== 8'h00) begin
      errs++;
      $display("FAIL rd_m0_hold: got %h want 00", bus.o_m0_rdata);
    end
  endtask

  task automatic test_contention();
    int t0, t1;
    logic both;
    t0 = 0;
    t1 = 0;
    both = 1'b0;
    do_reset();
    bus.i_m0_we    = 1'b1;
    bus.i_m0_addr  = 8'd4;
    bus.i_m0_wdata = 8'h5A;
    bus.i_m1_we    = 1'b0;
    bus.i_m1_addr  = 8'd4;
    bus.i_m0_req   = 1'b1;
    bus.i_m1_req   = 1'b1;
    for (int k = 1; k <= 12 && t1 == 0; k++) begin
      @(posedge clk); #1;
      if (bus.o_m0_ack === 1'b1 && bus.o_m1_ack === 1'b1)
        both = 1'b1;
      if (bus.o_m0_ack === 1'b1) begin
        t0 = k;
        bus.i_m0_req = 1'b0;
      end
      if (bus.o_m1_ack === 1'b1) begin
        t1 = k;
        bus.i_m1_req = 1'b0;
      end
    end
    checks++;
    if (t0 != 3 || t1 != 6) begin
      errs++;
      $display("FAIL cont_order: got m0@%0d m1@%0d want m0@3 m1@6",
               t0, t1);
    end
    checks++;
    if (both !== 1'b0) begin
      errs++;
      $display("FAIL cont_dual_ack: got 1 want 0");
    end
    checks++;
    if (bus.o_m0_rdata !== 8'h00 || bus.o_m1_rdata !== 8'h5A) begin
      errs++;
      $display("FAIL cont_data: got %h/%h want 00/5a",
               bus.o_m0_rdata, bus.o_m1_rdata);
    end
  endtask

  task automatic test_back_to_back();
    int n, prev;
    logic [5:0] seq;
    logic both, gap_bad;
    n = 0;
    prev = 0;
    seq = '0;
    both = 1'b0;
    gap_bad = 1'b0;
    @(negedge clk);
    bus.i_m0_we   = 1'b0;
    bus.i_m0_addr = 8'd2;
    bus.i_m1_we   = 1'b0;
    bus.i_m1_addr = 8'd4;
    bus.i_m0_req  = 1'b1;
    bus.i_m1_req  = 1'b1;
    for (int k = 1; k <= 40 && n < 6; k++) begin
      @(posedge clk); #1;
      if (bus.o_m0_ack === 1'b1 && bus.o_m1_ack === 1'b1)
        both = 1'b1;
      if (bus.o_m0_ack === 1'b1 || bus.o_m1_ack === 1'b1) begin
        seq[n] = bus.o_m1_ack;
        if (k - prev != 3) gap_bad = 1'b1;
        prev = k;
        n++;
      end
      if (n == 6) begin
        bus.i_m0_req = 1'b0;
        bus.i_m1_req = 1'b0;
      end
    end
    checks++;
    if (n != 6 || seq !== 6'b101010) begin
      errs++;
      $display("FAIL b2b_order: got n=%0d seq=%b want n=6 seq=101010",
               n, seq);
    end
    checks++;
    if (gap_bad !== 1'b0 || both !== 1'b0) begin
      errs++;
      $display("FAIL b2b_spacing: got gap_bad=%b dual=%b want 0/0",
               gap_bad, both);
    end
    checks++;
    if (bus.o_m0_rdata !== 8'hA5 || bus.o_m1_rdata !== 8'h5A) begin
      errs++;
      $display("FAIL b2b_data: got %h/%h want a5/5a",
               bus.o_m0_rdata, bus.o_m1_rdata);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.o_busy !== 1'b0) begin
      errs++;
      $display("FAIL b2b_idle: got busy=%b want 0", bus.o_busy);
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    logic late_ack;
    lat = 0;
    late_ack = 1'b0;
    @(negedge clk);
    bus.i_m1_we    = 1'b1;
    bus.i_m1_addr  = 8'd1;
    bus.i_m1_wdata = 8'h3C;
    bus.i_m1_req   = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.o_s_we !== 1'b1 || bus.o_s_addr !== 8'd1) begin
      errs++;
      $display("FAIL abort_issue: got we=%b a=%h want 1/01",
               bus.o_s_we, bus.o_s_addr);
    end
    rst = 1'b1;
    bus.i_m1_req = 1'b0;
    #1;
    checks++;
    if (bus.o_s_we !== 1'b0) begin
      errs++;
      $display("FAIL abort_we_gate: got %b want 0", bus.o_s_we);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.o_m0_ack !== 1'b0 || bus.o_m1_ack !== 1'b0 ||
        bus.o_busy !== 1'b0 || bus.o_s_we !== 1'b0) begin
      errs++;
      $display("FAIL abort_ctrl: got ack=%b%b busy=%b we=%b want 00/0/0",
               bus.o_m1_ack, bus.o_m0_ack, bus.o_busy, bus.o_s_we);
    end
    checks++;
    if (bus.o_s_addr !== 8'h00 || bus.o_s_wdata !== 8'h00 ||
        bus.o_m0_rdata !== 8'h00 || bus.o_m1_rdata !== 8'h00) begin
      errs++;
      $display("FAIL abort_data: got a=%h d=%h r0=%h r1=%h want all 00",
               bus.o_s_addr, bus.o_s_wdata,
               bus.o_m0_rdata, bus.o_m1_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (bus.o_m0_ack === 1'b1 || bus.o_m1_ack === 1'b1)
        late_ack = 1'b1;
    end
    checks++;
    if (late_ack !== 1'b0) begin
      errs++;
      $display("FAIL abort_no_ack: got 1 want 0");
    end
    @(negedge clk);
    bus.i_m0_we   = 1'b0;
    bus.i_m0_addr = 8'd1;
    bus.i_m0_req  = 1'b1;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (bus.o_m0_ack === 1'b1) begin
        lat = k;
        bus.i_m0_req = 1'b0;
      end
    end
    checks++;
    if (lat != 3 || bus.o_m0_rdata !== 8'h00) begin
      errs++;
      $display("FAIL abort_reg1: got lat=%0d data=%h want 3/00",
               lat, bus.o_m0_rdata);
    end
    checks++;
    if (mem[1] !== 8'h00) begin
      errs++;
      $display("FAIL abort_mem: got %h want 00", mem[1]);
    end
  endtask

  initial begin
    bus.i_m0_req   = 1'b0;
    bus.i_m0_we    = 1'b0;
    bus.i_m0_addr  = '0;
    bus.i_m0_wdata = '0;
    bus.i_m1_req   = 1'b0;
    bus.i_m1_we    = 1'b0;
    bus.i_m1_addr  = '0;
    bus.i_m1_wdata = '0;
    do_reset();
    test_reset();
    test_write_m0();
    test_read_m1();
    test_contention();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
